// File: rtl/fcore_isa.sv
// Shared fCore types for the writeback path: register-file entry layout and
// the round-robin pointer step.
package fcore_isa;

  localparam int REG_ADDR_WIDTH = 6;
  localparam int DATA_WIDTH     = 32;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_stream.sv
// Minimal AXI-stream bundle carrying a result word and its user sideband.
// A beat transfers on a clock edge where valid and ready are both high;
// the master must hold data/user stable while valid is high and ready is low.
interface axi_stream #(
  parameter int DATA_W = 32,
  parameter int USER_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [USER_W-1:0] user;

  modport master (output valid, output data, output user, input ready);
  modport slave  (input valid, input data, input user, output ready);
endinterface

// File: rtl/fcore_wb_fifo.sv
// Synchronous FIFO of writeback entries; push and pop may coincide when full,
// a push to a full FIFO without a pop is ignored by the FIFO itself.
module fcore_wb_fifo
  import fcore_isa::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      empty,
  output logic      full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit separates the full and empty cases.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fcore_writeback_arbiter.sv
// Buffers each execution unit's result stream and round-robin serialises them
// onto the register-file write port. Optional: FCORE_WB_CONTENTION_COUNT_EN.
module fcore_writeback_arbiter
  import fcore_isa::*;
#(
  parameter int N_UNITS        = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REG_ADDR_WIDTH = fcore_isa::REG_ADDR_WIDTH,
  parameter int DATA_WIDTH     = fcore_isa::DATA_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  axi_stream.slave                  unit_result [N_UNITS],
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0]     rf_data,
  output logic [N_UNITS-1:0]        overflow,
  input  logic                      clear_overflow,
  output logic                      busy
`ifdef FCORE_WB_CONTENTION_COUNT_EN
  ,
  output logic [31:0]               contention_count
`endif
);

  localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic [N_UNITS-1:0] push;
  logic [N_UNITS-1:0] pop;
  logic [N_UNITS-1:0] empty;
  logic [N_UNITS-1:0] full;
  logic [N_UNITS-1:0] drop;
  logic [N_UNITS-1:0] req;
  logic [N_UNITS-1:0] unused_user;
  wb_entry_t          fifo_din  [N_UNITS];
  wb_entry_t          fifo_dout [N_UNITS];

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;

  for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
    // Units cannot be stalled, so every beat is accepted and buffered.
    assign unit_result[i].ready = 1'b1;
    assign push[i]              = unit_result[i].valid;
    assign fifo_din[i].addr     = unit_result[i].user[REG_ADDR_WIDTH-1:0];
    assign fifo_din[i].data     = unit_result[i].data[DATA_WIDTH-1:0];
    assign unused_user[i]       = ^unit_result[i].user[31:REG_ADDR_WIDTH];
    assign drop[i]              = push[i] & full[i] & ~pop[i];

    fcore_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (fifo_din[i]),
      .dout  (fifo_dout[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  assign req  = ~empty;
  assign busy = (|req) | rf_we;

  // Scan from rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    logic [PTR_W:0] sum;
    grant_valid = 1'b0;
    grant_idx   = '0;
    pop         = '0;
    sum         = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_UNITS)) sum = sum - (PTR_W+1)'(N_UNITS);
      if (!grant_valid && req[sum[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = sum[PTR_W-1:0];
      end
    end
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      rr_ptr   <= '0;
      overflow <= '0;
    end else begin
      rf_we <= grant_valid;
      if (grant_valid) begin
        rf_addr <= fifo_dout[grant_idx].addr;
        rf_data <= fifo_dout[grant_idx].data;
        rr_ptr  <= PTR_W'(rr_next(32'(grant_idx), N_UNITS));
      end
      // A drop on the same edge as clear_overflow keeps its flag set.
      overflow <= (overflow & {N_UNITS{~clear_overflow}}) | drop;
    end
  end

`ifdef FCORE_WB_CONTENTION_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset || clear_overflow) begin
      contention_count <= '0;
    end else if ($countones(req) > 1 && contention_count != 32'hFFFF_FFFF) begin
      contention_count <= contention_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fcore_writeback_arbiter.sv
// Randomised and directed bench for fcore_writeback_arbiter against a
// queue-based reference model of the buffering and round-robin rules.
module tb_fcore_writeback_arbiter;
  import fcore_isa::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int W     = $bits(wb_entry_t);

  logic             clock;
  logic             reset;
  logic             clear_overflow;
  logic             rf_we;
  logic [5:0]       rf_addr;
  logic [31:0]      rf_data;
  logic [N-1:0]     overflow;
  logic             busy;
`ifdef FCORE_WB_CONTENTION_COUNT_EN
  logic [31:0]      contention_count;
`endif

  logic [N-1:0]     tb_valid;
  logic [31:0]      tb_data [N];
  logic [31:0]      tb_user [N];
  logic [N-1:0]     tb_ready;

  axi_stream units [N] ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign units[g].valid = tb_valid[g];
    assign units[g].data  = tb_data[g];
    assign units[g].user  = tb_user[g];
    assign tb_ready[g]    = units[g].ready;
  end

  fcore_writeback_arbiter #(
    .N_UNITS        (N),
    .FIFO_DEPTH     (DEPTH),
    .REG_ADDR_WIDTH (6),
    .DATA_WIDTH     (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .unit_result      (units),
    .rf_we            (rf_we),
    .rf_addr          (rf_addr),
    .rf_data          (rf_data),
    .overflow         (overflow),
    .clear_overflow   (clear_overflow),
    .busy             (busy)
`ifdef FCORE_WB_CONTENTION_COUNT_EN
    ,
    .contention_count (contention_count)
`endif
  );

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: per-unit pending entries plus expected outputs.
  logic [W-1:0] exp_q [N][$];
  int           rr;
  logic         e_we;
  logic [5:0]   e_addr;
  logic [31:0]  e_data;
  logic [N-1:0] e_ov;
  logic [31:0]  e_cnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int u, input logic [31:0] d, input logic [31:0] usr);
    tb_valid[u] = 1'b1;
    tb_data[u]  = d;
    tb_user[u]  = usr;
  endtask

  // One clock: advance the model with the inputs sampled at the edge,
  // then compare every output and release the one-cycle inputs.
  task automatic step();
    int           g;
    int           busy_cnt;
    bit           found;
    logic [W-1:0] w;
    logic [N-1:0] drops;
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      rr = 0; e_we = 0; e_addr = '0; e_data = '0; e_ov = '0; e_cnt = '0;
    end else begin
      found = 0; g = 0; busy_cnt = 0;
      for (int k = 0; k < N; k++) begin
        if (exp_q[k].size() > 0) busy_cnt++;
        if (!found && exp_q[(rr + k) % N].size() > 0) begin
          found = 1;
          g = (rr + k) % N;
        end
      end
      if (clear_overflow) e_cnt = '0;
      else if (busy_cnt > 1 && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
      e_we = found;
      if (found) begin
        w      = exp_q[g].pop_front();
        e_addr = w[W-1 -: 6];
        e_data = w[31:0];
        rr     = (g + 1) % N;
      end
      drops = '0;
      for (int i = 0; i < N; i++) begin
        if (tb_valid[i]) begin
          if (exp_q[i].size() < DEPTH) exp_q[i].push_back({tb_user[i][5:0], tb_data[i]});
          else drops[i] = 1'b1;
        end
      end
      e_ov = (clear_overflow ? '0 : e_ov) | drops;
    end
    #1;
    check("rf_we", 64'(rf_we), 64'(e_we));
    check("rf_addr", 64'(rf_addr), 64'(e_addr));
    check("rf_data", 64'(rf_data), 64'(e_data));
    check("overflow", 64'(overflow), 64'(e_ov));
    busy_cnt = 0;
    for (int i = 0; i < N; i++) if (exp_q[i].size() > 0) busy_cnt++;
    check("busy", 64'(busy), 64'((busy_cnt > 0) || e_we));
    check("ready", 64'(tb_ready), 64'({N{1'b1}}));
`ifdef FCORE_WB_CONTENTION_COUNT_EN
    check("contention_count", 64'(contention_count), 64'(e_cnt));
`endif
    tb_valid       = '0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_overflow = 1'b0;
    tb_valid = '0;
    for (int i = 0; i < N; i++) begin
      tb_data[i] = '0;
      tb_user[i] = '0;
    end

    // Reset state
    step();
    step();
    reset = 1'b0;
    step();

    // Single beat from unit 2: write two clocks later, busy clears after.
    set_beat(2, 32'h1, 32'd5);
    step();
    check("single_latency_we0", 64'(rf_we), 64'(0));
    step();
    check("single_we", 64'(rf_we), 64'(1));
    check("single_addr", 64'(rf_addr), 64'(5));
    check("single_data", 64'(rf_data), 64'(1));
    step();
    check("single_busy_low", 64'(busy), 64'(0));
    check("single_hold_addr", 64'(rf_addr), 64'(5));

    // All four units on one edge from a fresh round-robin pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int u = 0; u < N; u++) set_beat(u, 32'hA0 + 32'(u), 32'(u + 1));
    step();
    for (int c = 0; c < N; c++) begin
      step();
      check("rr_order_addr", 64'(rf_addr), 64'(c + 1));
    end
    step();
    set_beat(0, 32'hBEEF, 32'd9);
    set_beat(3, 32'hCAFE, 32'd10);
    step();
    step();
    check("rr_wraps_to_unit0", 64'(rf_addr), 64'(9));
    repeat (3) step();

    // Overflow on unit 0 while every other unit streams too.
    for (int c = 0; c < 8; c++) begin
      for (int u = 0; u < N; u++) set_beat(u, 32'(c * 16 + u), 32'($urandom));
      step();
    end
    check("overflow0_set", 64'(overflow[0]), 64'(1));
    repeat (20) step();
    clear_overflow = 1'b1;
    step();
    check("overflow_cleared", 64'(overflow), 64'(0));

    // Reset with entries buffered discards them.
    for (int c = 0; c < 3; c++) begin
      for (int u = 0; u < N; u++) set_beat(u, $urandom, $urandom);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("post_reset_we", 64'(rf_we), 64'(0));
    check("post_reset_busy", 64'(busy), 64'(0));
    repeat (3) step();

    // Randomised traffic with varying load and occasional clears.
    for (int c = 0; c < 600; c++) begin
      int load;
      load = (c / 100) % 3;
      for (int u = 0; u < N; u++) begin
        if ($urandom_range(0, 3) < load + 1) set_beat(u, $urandom, $urandom);
      end
      if ($urandom_range(0, 31) == 0) clear_overflow = 1'b1;
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    repeat (24) step();
    check("drained_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
